acc_frame_sequencer: RTL
========================

// Module: acc_frame_sequencer
// PURPOSE
//  Frame controller for the 8-bit accumulator datapath (adder + voted register).
//  Accepts a frame of cfg_len samples over valid/ready, clears the accumulator,
//  feeds one sample per accepted beat, waits for the register to settle, then
//  presents the sum on a valid/ready result port. Sits between the stream source
//  and the accumulator; the accumulator adds acc_din every clock.
// PARAMETERS
//  WIDTH  8  data width of samples, accumulator and result
//  LEN_W  8  width of cfg_len; frame length 0 means 2**LEN_W samples
// PORTS
//  clk        in   1      single clock, rising edge
//  rstn       in   1      asynchronous active-low reset
//  cfg_len    in   LEN_W  samples per frame, sampled on accepted start
//  start      in   1      start pulse; accepted only in IDLE
//  in_valid   in   1      sample valid
//  in_data    in   WIDTH  sample value
//  in_ready   out  1      sample accepted when in_valid & in_ready
//  acc_rst    out  1      registered clear pulse to accumulator (active-high)
//  acc_din    out  WIDTH  addend to accumulator; 0 when no beat accepted
//  acc_dout   in   WIDTH  current accumulator register value
//  out_valid  out  1      result valid
//  out_data   out  WIDTH  frame sum (mod 2**WIDTH)
//  out_ready  in   1      result consumed when out_valid & out_ready
//  out_ovf    out  1      sum wrapped during frame; valid with out_valid
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, acc_rst, out_valid, out_ovf, busy = 0;
//   acc_din, out_data = 0; counter = 0, latched length = 0.
//  FSM (all outputs registered or decoded from state, no comb in->out path
//   except acc_din = in_valid & in_ready ? in_data : 0):
//   IDLE : start=1 -> latch len (0 -> 2**LEN_W, LEN_W+1-bit), cnt=0, ovf=0 -> CLEAR
//   CLEAR: acc_rst=1 this cycle only -> RUN
//   RUN  : in_ready=1; on beat: cnt++, ovf |= carry(acc_dout + in_data);
//          beat with cnt+1 == len -> DRAIN (in_ready low from next cycle)
//   DRAIN: in_ready=0, acc_din=0; one cycle for accumulator register update -> HOLD
//   HOLD : out_valid=1, out_data=acc_dout captured on DRAIN->HOLD edge,
//          out_ovf=ovf; stays until out_ready=1 -> IDLE (out_valid low next cycle)
//  Latency: last sample beat to out_valid = 2 cycles.
//  Back-to-back: start may be asserted in the cycle out_valid drops; start
//   in any non-IDLE state ignored (no queueing).
//  In RUN with in_valid=0 accumulator holds (adds 0); gaps of any length legal.
//  Overflow: sum wraps mod 2**WIDTH; out_ovf sticky for the frame.
//  Carry uses acc_dout; valid because at most one beat enters per cycle and the
//   accumulator register updates on the same edge the beat is taken.
//  cfg_len changes after start do not affect the running frame.
//  rstn asserted mid-frame: immediate return to reset values; partial frame lost.
// CONFIGURATION
//  ACC_SEQ_TMR_ERR_CNT_EN defined: adds input tmr_err (1, OR of voter tmrErr) and
//   output err_cnt (8, saturating at 255, cleared only by rstn), counting
//   cycles with tmr_err=1 in any state. Undefined: ports absent, no logic.
// TESTING
//  T1 cfg_len=4, start, samples 1,2,3,4 no gaps -> out_valid 2 clk after last
//     beat, out_data=10, out_ovf=0, busy drops after out_ready.
//  T2 cfg_len=2, samples 200,100 -> out_data=44, out_ovf=1.
//  T3 cfg_len=3, in_valid toggling 1,0,0,1,0,1 (5,6,7) and out_ready low 5
//     cycles -> out_data=18 held stable until out_ready, then IDLE.
//  T4 cfg_len=0 with 256 beats of 1 -> out_data=0, out_ovf=1, exactly 256 beats
//     accepted, in_ready low after 256th.
//  T5 start pulsed during RUN and HOLD -> ignored; rstn low after 2 of 4 beats ->
//     all outputs at reset values, next frame (len=1, 9) -> out_data=9.
//  T6 (macro) tmr_err high 3 cycles during frame -> err_cnt=3; 300 cycles -> 255.

Source files
------------

// File: rtl/acc_frame_sequencer.sv
// Frame controller for the 8-bit accumulator datapath: clears, feeds and reads back one frame.
// Optional ACC_SEQ_TMR_ERR_CNT_EN adds a saturating counter of voter error cycles.
module acc_frame_sequencer #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             acc_rst,
   output logic [WIDTH-1:0] acc_din,
   input  logic [WIDTH-1:0] acc_dout,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             out_ovf,
   output logic             busy
`ifdef ACC_SEQ_TMR_ERR_CNT_EN
   ,
   input  logic             tmr_err,
   output logic [7:0]       err_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_HOLD
   } state_t;

   // cfg_len of zero stands for a full 2**LEN_W-sample frame
   localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

   state_t           r_state;
   logic [LEN_W:0]   r_len;
   logic [LEN_W:0]   r_cnt;
   logic             r_ovf;
   logic             r_in_ready;
   logic             r_acc_rst;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_ovf;
   logic             r_busy;

   logic             w_beat;
   logic [LEN_W:0]   w_cnt_nxt;
   logic [WIDTH-1:0] w_wrap;
   logic             w_carry;

   assign w_beat    = in_valid & r_in_ready;
   assign w_cnt_nxt = r_cnt + (LEN_W+1)'(1);
   // acc_dout already holds every earlier beat, so this is the carry of the beat being taken
   assign w_wrap    = acc_dout + in_data;
   assign w_carry   = (w_wrap < acc_dout);

   assign in_ready  = r_in_ready;
   assign acc_rst   = r_acc_rst;
   assign acc_din   = w_beat ? in_data : '0;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_ovf   = r_out_ovf;
   assign busy      = r_busy;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_cnt       <= '0;
         r_ovf       <= 1'b0;
         r_in_ready  <= 1'b0;
         r_acc_rst   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ovf   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_acc_rst <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len     <= (cfg_len == '0) ? FULL_LEN : {1'b0, cfg_len};
                  r_cnt     <= '0;
                  r_ovf     <= 1'b0;
                  r_acc_rst <= 1'b1;
                  r_busy    <= 1'b1;
                  r_state   <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               r_in_ready <= 1'b1;
               r_state    <= S_RUN;
            end
            S_RUN: begin
               if (w_beat) begin
                  r_cnt <= w_cnt_nxt;
                  r_ovf <= r_ovf | w_carry;
                  if (w_cnt_nxt == r_len) begin
                     r_in_ready <= 1'b0;
                     r_state    <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               r_out_data  <= acc_dout;
               r_out_ovf   <= r_ovf;
               r_out_valid <= 1'b1;
               r_state     <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ACC_SEQ_TMR_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   assign err_cnt = r_err_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err_cnt <= '0;
      end else if (tmr_err && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end
   end
`endif

endmodule
